instr_fetch_stage: RTL and testbench



---
 rtl/instr_fetch_stage_if.sv | 26 ++
 rtl/instr_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, decode-side controls and the IF/ID output register.
// The master modport is the fetch stage itself; the slave modport is its environment (memory + decode).
interface instr_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              id_stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc4,
    input  imem_ack, imem_rdata, id_stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc4,
    output imem_ack, imem_rdata, id_stall, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// MIPS instruction-fetch stage: PC, req/ack fetch, one-entry skid buffer, branch redirect with flush.
// Optional macro IF_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module instr_fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_bubbles
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, FULL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              transfer;

  // In DROP the PC already points at the branch target, so the stale address is held separately.
  assign req      = (state_q == REQ) || (state_q == DROP);
  assign addr     = (state_q == DROP) ? drop_addr_q : {pc_q[ADDR_W-1:2], 2'b00};
  assign transfer = req && bus.imem_ack;

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc4    = pc4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    if (valid_q && !bus.id_stall) begin
      valid_d = 1'b0;
    end

    if (bus.branch_taken) begin
      pc_d    = {bus.branch_target[ADDR_W-1:2], 2'b00};
      valid_d = 1'b0;
      if (req && !bus.imem_ack) begin
        state_d = DROP;
        if (state_q == REQ) begin
          drop_addr_d = addr;
        end
      end else begin
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (transfer) begin
            pc_d = pc_q + ADDR_W'(4);
            if (!valid_q || !bus.id_stall) begin
              valid_d = 1'b1;
              instr_d = bus.imem_rdata;
              pc4_d   = addr + ADDR_W'(4);
            end else begin
              skid_instr_d = bus.imem_rdata;
              skid_pc4_d   = addr + ADDR_W'(4);
              state_d      = FULL;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_d = REQ;
          end
        end
        FULL: begin
          if (!bus.id_stall) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            pc4_d   = skid_pc4_q;
            state_d = REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        fetch_load;
  logic [31:0] fetched_q;
  logic [31:0] bubbles_q;

  // Only transfers that land in the output register or skid count; dropped data does not.
  assign fetch_load = transfer && !bus.branch_taken && (state_q == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (fetch_load) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if ((state_q != IDLE) && !valid_q) begin
        bubbles_q <= bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: table-driven per-cycle vectors plus hand-written
// latency, drop-on-redirect and mid-request reset sequences (perf counters when IF_PERF_CNT_EN).
module tb_instr_fetch_stage;

  logic clk;
  logic rst_n;
  int   testsRun  = 0;
  int   failCount = 0;
  int   memLat    = 0;
  int   memCnt;
  bit   ok;

  instr_fetch_stage_if #(.ADDR_W(32)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetched;
  logic [31:0] perfBubbles;
`endif

  instr_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched (perfFetched),
    .perf_bubbles (perfBubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h8C00_0000 | a;
  endfunction

  // Memory acks once the request has been held for memLat extra cycles (0 = zero-wait).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) memCnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) memCnt <= 0;
    else memCnt <= memCnt + 1;
  end
  assign bus.imem_ack   = bus.imem_req && (memCnt >= memLat);
  assign bus.imem_rdata = memWord(bus.imem_addr);

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc4;
  } vec_t;

  vec_t vecs[14];

  task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] tgt);
    bus.id_stall      = stall;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Leaves time at mid-cycle of the first cycle with if_valid high.
  task automatic waitValid(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #4;
      if (bus.if_valid) begin
        found = 1'b1;
        break;
      end
      stepCycle();
    end
  endtask

  task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                          input logic eValid);
    checkOutput({tag, " req"},   {31'b0, bus.imem_req}, {31'b0, eReq});
    checkOutput({tag, " addr"},  bus.imem_addr, eAddr);
    checkOutput({tag, " valid"}, {31'b0, bus.if_valid}, {31'b0, eValid});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,             32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,             32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h8C00_0000,     32'h4};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h8C00_0000,     32'h4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h8C00_0000,     32'h4};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h8C00_0000,     32'h4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h8C00_0000,     32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h8C00_0004,     32'h8};
    vecs[8]  = '{1'b0, 1'b1, 32'h43,  1'b1, 32'hC,   1'b1, 32'h8C00_0008,     32'hC};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0,             32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h100, 1'b1, 32'h44,  1'b1, 32'h8C00_0040,     32'h44};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,             32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h8C00_0100,     32'h104};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h8C00_0104,     32'h108};

    rst_n  = 1'b0;
    memLat = 0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    checkAll("rst", 1'b0, 32'h0, 1'b0);
    checkOutput("rst instr", bus.if_instr, 32'h0);
    checkOutput("rst pc4",   bus.if_pc4,   32'h0);

    // Zero-wait stream, 4-cycle stall into FULL, branch to 0x43, branch under stall.
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].tgt);
      #4;
      checkAll($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid);
      if (vecs[i].eValid) begin
        checkOutput($sformatf("vec%0d instr", i), bus.if_instr, vecs[i].eInstr);
        checkOutput($sformatf("vec%0d pc4", i),   bus.if_pc4,   vecs[i].ePc4);
      end
      stepCycle();
    end

    // Slow memory: request held 3 cycles with a stable address, if_valid pulses.
    memLat = 2;
    doReset();
    stepCycle();
    for (int c = 1; c <= 3; c++) begin
      #4;
      checkAll($sformatf("lat c%0d", c), 1'b1, 32'h0, 1'b0);
      stepCycle();
    end
    #4;
    checkAll("lat c4", 1'b1, 32'h4, 1'b1);
    checkOutput("lat c4 instr", bus.if_instr, 32'h8C00_0000);
    checkOutput("lat c4 pc4",   bus.if_pc4,   32'h4);
    stepCycle();
    #4;
    checkAll("lat c5", 1'b1, 32'h4, 1'b0);
    stepCycle();
    #4;
    checkAll("lat c6", 1'b1, 32'h4, 1'b0);
    stepCycle();
    #4;
    checkAll("lat c7", 1'b1, 32'h8, 1'b1);
    checkOutput("lat c7 instr", bus.if_instr, 32'h8C00_0004);
    checkOutput("lat c7 pc4",   bus.if_pc4,   32'h8);
    stepCycle();

    // Redirect while the request to 0x8 is outstanding: its data must be dropped.
    memLat = 1;
    doReset();
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #4;
      if (bus.imem_req && bus.imem_addr == 32'h8) begin
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("drop reach 0x8", {31'b0, ok}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h40);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    #4;
    checkAll("drop hold", 1'b1, 32'h8, 1'b0);
    stepCycle();
    #4;
    checkAll("drop redirect", 1'b1, 32'h40, 1'b0);
    waitValid(10, ok);
    checkOutput("drop wait", {31'b0, ok}, 32'h1);
    checkOutput("drop instr", bus.if_instr, 32'h8C00_0040);
    checkOutput("drop pc4",   bus.if_pc4,   32'h44);
    stepCycle();

    // Asynchronous reset while a request is waiting, then refetch from RESET_PC.
    memLat = 3;
    doReset();
    waitValid(20, ok);
    checkOutput("mid wait", {31'b0, ok}, 32'h1);
    checkOutput("mid pre addr", bus.imem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    checkAll("mid rst", 1'b0, 32'h0, 1'b0);
    checkOutput("mid rst instr", bus.if_instr, 32'h0);
    checkOutput("mid rst pc4",   bus.if_pc4,   32'h0);
    memLat = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    waitValid(10, ok);
    checkOutput("refetch wait", {31'b0, ok}, 32'h1);
    checkOutput("refetch instr", bus.if_instr, 32'h8C00_0000);
    checkOutput("refetch pc4",   bus.if_pc4,   32'h4);
    stepCycle();

`ifdef IF_PERF_CNT_EN
    // Ten fetches with a 2-cycle stall; only the cycle right after IDLE is empty.
    memLat = 0;
    doReset();
    for (int c = 0; c <= 12; c++) begin
      applyStimulus((c == 2) || (c == 3), 1'b0, 32'h0);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    #4;
    checkOutput("perf fetched", perfFetched, 32'd10);
    checkOutput("perf bubbles", perfBubbles, 32'd1);
    stepCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
